// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: address width helper,
// register index type and the hardwired-zero register index.
package rf_pkg;

    localparam int RF_NUM_REGS_DEF = 32;

    // Address width for a register count; a single-register file still needs one bit.
    function automatic int rf_aw(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

    typedef logic [rf_aw(RF_NUM_REGS_DEF)-1:0] rf_idx_t;

    localparam int ZERO_IDX = 0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports and the
// busy-set strobe used at producer issue.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][AW-1:0]     wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic                          busy_set;
    logic [AW-1:0]                 busy_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/reg_file_mp_read_port.sv
// One combinational read port: array select, write-port bypass (highest port
// wins), zero-register mask and busy masking.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = rf_aw(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [NUM_REGS-1:0]             busy_i,
    input  logic [AW-1:0]                   rd_addr_i,
    input  logic [NUM_WR-1:0]               wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0]       wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]   wr_data_i,
    output logic [DATA_W-1:0]               rd_data_o,
    output logic                            rd_busy_o
);

    // Stored value, overridden by in-flight writes, then forced to zero for r0.
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
        if (BYPASS != 0) begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en_i[i] && (wr_addr_i[i] == rd_addr_i)) begin
                    rd_data_o = wr_data_i[i];
                    rd_busy_o = 1'b0;
                end
            end
        end
        if ((ZERO_REG != 0) && (rd_addr_i == AW'(ZERO_IDX))) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with bypass, hardwired zero register and a
// per-register busy scoreboard for decode stalls.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    localparam int AW = rf_aw(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [NUM_WR-1:0]               wr_en_live;

    // Writes never forward while reset is held, so reads stay zero during reset.
    assign wr_en_live = bus.wr_en & {NUM_WR{rst_n}};

    // Next state: writes in port order (last port wins), then busy-set overrides the clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < NUM_WR; i++) begin
            if (bus.wr_en[i] &&
                !((ZERO_REG != 0) && (bus.wr_addr[i] == AW'(ZERO_IDX)))) begin
                regs_d[bus.wr_addr[i]] = bus.wr_data[i];
                busy_d[bus.wr_addr[i]] = 1'b0;
            end
        end
        if (bus.busy_set &&
            !((ZERO_REG != 0) && (bus.busy_addr == AW'(ZERO_IDX)))) begin
            busy_d[bus.busy_addr] = 1'b1;
        end
    end

    // Storage and scoreboard; reset discards everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .NUM_WR   (NUM_WR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG),
            .AW       (AW)
        ) u_rd (
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .rd_addr_i (bus.rd_addr[j]),
            .wr_en_i   (wr_en_live),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .rd_data_o (bus.rd_data[j]),
            .rd_busy_o (bus.rd_busy[j])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: dut_a has two write ports with bypass, dut_b one write
// port without bypass (it sees only write port 0 of the shared stimulus).
module tb_reg_file_mp;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(32), .AW(5), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    reg_file_mp_if #(.DATA_W(32), .AW(5), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
                  .BYPASS(1), .ZERO_REG(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

    reg_file_mp #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1),
                  .BYPASS(0), .ZERO_REG(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int total = 0;
    int bad   = 0;

    // shared stimulus
    logic [1:0]  s_wen;
    logic [4:0]  s_wa [2];
    logic [31:0] s_wd [2];
    logic        s_bset;
    logic [4:0]  s_ba;
    logic [4:0]  s_ra [2];

    // reference state per dut (0 = bypass/2 writers, 1 = no bypass/1 writer)
    logic [31:0] m_reg  [2][32];
    bit          m_busy [2][32];

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        bset;
        logic [4:0]  ba;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ad0; logic ab0; logic [31:0] ad1; logic ab1;
        logic [31:0] bd0; logic bb0; logic [31:0] bd1; logic bb1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        logic [1:0] wen, logic [4:0] wa0, logic [31:0] wd0, logic [4:0] wa1, logic [31:0] wd1,
        logic bset, logic [4:0] ba, logic [4:0] ra0, logic [4:0] ra1,
        logic [31:0] ad0, logic ab0, logic [31:0] ad1, logic ab1,
        logic [31:0] bd0, logic bb0, logic [31:0] bd1, logic bb1);
        vec_t v;
        v.wen = wen; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.bset = bset; v.ba = ba; v.ra0 = ra0; v.ra1 = ra1;
        v.ad0 = ad0; v.ab0 = ab0; v.ad1 = ad1; v.ab1 = ab1;
        v.bd0 = bd0; v.bb0 = bb0; v.bd1 = bd1; v.bb1 = bb1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        bus_a.wr_en      = s_wen;
        bus_a.wr_addr[0] = s_wa[0];
        bus_a.wr_addr[1] = s_wa[1];
        bus_a.wr_data[0] = s_wd[0];
        bus_a.wr_data[1] = s_wd[1];
        bus_a.busy_set   = s_bset;
        bus_a.busy_addr  = s_ba;
        bus_a.rd_addr[0] = s_ra[0];
        bus_a.rd_addr[1] = s_ra[1];
        bus_b.wr_en      = s_wen[0];
        bus_b.wr_addr[0] = s_wa[0];
        bus_b.wr_data[0] = s_wd[0];
        bus_b.busy_set   = s_bset;
        bus_b.busy_addr  = s_ba;
        bus_b.rd_addr[0] = s_ra[0];
        bus_b.rd_addr[1] = s_ra[1];
    endtask

    task automatic set_idle();
        s_wen = 2'b00; s_wa[0] = '0; s_wa[1] = '0; s_wd[0] = '0; s_wd[1] = '0;
        s_bset = 1'b0; s_ba = '0;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++) begin
                m_reg[k][r]  = '0;
                m_busy[k][r] = 1'b0;
            end
    endtask

    // Expected read: r0 is always 0/idle; otherwise stored state, and for the
    // bypassing dut the highest-numbered matching write port supplies the data.
    task automatic model_read(input int k, input int a, output logic [31:0] d, output logic b);
        d = m_reg[k][a];
        b = m_busy[k][a];
        if (k == 0) begin
            for (int i = 1; i >= 0; i--) begin
                if (s_wen[i] && (int'(s_wa[i]) == a)) begin
                    d = s_wd[i];
                    b = 1'b0;
                    break;
                end
            end
        end
        if (a == 0) begin
            d = '0;
            b = 1'b0;
        end
    endtask

    // Clock edge effect on the reference: winning writer per address, then busy-set.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int nports = (k == 0) ? 2 : 1;
            for (int i = 0; i < nports; i++) begin
                if (s_wen[i] && s_wa[i] != 0) begin
                    m_reg[k][s_wa[i]]  = s_wd[i];
                    m_busy[k][s_wa[i]] = 1'b0;
                end
            end
            if (s_bset && s_ba != 0) m_busy[k][s_ba] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] d;
        logic        b;
        for (int j = 0; j < 2; j++) begin
            model_read(0, int'(s_ra[j]), d, b);
            chk($sformatf("%s_a_data%0d", tag, j), bus_a.rd_data[j], d);
            chk($sformatf("%s_a_busy%0d", tag, j), {31'b0, bus_a.rd_busy[j]}, {31'b0, b});
            model_read(1, int'(s_ra[j]), d, b);
            chk($sformatf("%s_b_data%0d", tag, j), bus_b.rd_data[j], d);
            chk($sformatf("%s_b_busy%0d", tag, j), {31'b0, bus_b.rd_busy[j]}, {31'b0, b});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("%s_a_data%0d", tag, j), bus_a.rd_data[j], 32'h0);
            chk($sformatf("%s_a_busy%0d", tag, j), {31'b0, bus_a.rd_busy[j]}, 32'h0);
            chk($sformatf("%s_b_data%0d", tag, j), bus_b.rd_data[j], 32'h0);
            chk($sformatf("%s_b_busy%0d", tag, j), {31'b0, bus_b.rd_busy[j]}, 32'h0);
        end
    endtask

    initial begin
        // directed table, starting from the reset state
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 5, 7,  0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(2'b01, 7, 32'h12345678, 0, 0, 0, 0, 7, 0,
                           32'h12345678, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 7, 7,
                           32'h12345678, 0, 32'h12345678, 0,  32'h12345678, 0, 32'h12345678, 0));
        vecs.push_back(mkv(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 1, 3, 3, 7,
                           0, 0, 32'h12345678, 0,  0, 0, 32'h12345678, 0));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 3, 3,  0, 1, 0, 1,  0, 1, 0, 1));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 3, 7,
                           0, 1, 32'h12345678, 0,  0, 1, 32'h12345678, 0));
        vecs.push_back(mkv(2'b01, 3, 32'hA5, 0, 0, 0, 0, 3, 3,
                           32'hA5, 0, 32'hA5, 0,  0, 1, 0, 1));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 3, 3,
                           32'hA5, 0, 32'hA5, 0,  32'hA5, 0, 32'hA5, 0));
        vecs.push_back(mkv(2'b01, 9, 32'h55, 0, 0, 1, 9, 9, 9,
                           32'h55, 0, 32'h55, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 9, 9,
                           32'h55, 1, 32'h55, 1,  32'h55, 1, 32'h55, 1));
        vecs.push_back(mkv(2'b11, 4, 32'h11, 4, 32'h22, 0, 0, 4, 9,
                           32'h22, 0, 32'h55, 1,  0, 0, 32'h55, 1));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 4, 4,
                           32'h22, 0, 32'h22, 0,  32'h11, 0, 32'h11, 0));
        vecs.push_back(mkv(2'b01, 9, 32'h66, 0, 0, 0, 0, 9, 3,
                           32'h66, 0, 32'hA5, 0,  32'h55, 1, 32'hA5, 0));
        vecs.push_back(mkv(2'b11, 12, 32'h1, 0, 32'h77, 0, 0, 0, 12,
                           0, 0, 32'h1, 0,  0, 0, 0, 0));
        vecs.push_back(mkv(2'b00, 0, 0, 0, 0, 0, 0, 12, 9,
                           32'h1, 0, 32'h66, 0,  32'h1, 0, 32'h66, 0));

        model_clear();
        set_idle();
        s_ra[0] = 5'd5;
        s_ra[1] = 5'd31;
        apply();
        rst_n = 1'b0;
        #2;
        chk_all_zero("reset_held");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            s_wen = vecs[n].wen;
            s_wa[0] = vecs[n].wa0; s_wd[0] = vecs[n].wd0;
            s_wa[1] = vecs[n].wa1; s_wd[1] = vecs[n].wd1;
            s_bset = vecs[n].bset; s_ba = vecs[n].ba;
            s_ra[0] = vecs[n].ra0; s_ra[1] = vecs[n].ra1;
            apply();
            @(negedge clk);
            chk($sformatf("v%0d_a_data0", n), bus_a.rd_data[0], vecs[n].ad0);
            chk($sformatf("v%0d_a_busy0", n), {31'b0, bus_a.rd_busy[0]}, {31'b0, vecs[n].ab0});
            chk($sformatf("v%0d_a_data1", n), bus_a.rd_data[1], vecs[n].ad1);
            chk($sformatf("v%0d_a_busy1", n), {31'b0, bus_a.rd_busy[1]}, {31'b0, vecs[n].ab1});
            chk($sformatf("v%0d_b_data0", n), bus_b.rd_data[0], vecs[n].bd0);
            chk($sformatf("v%0d_b_busy0", n), {31'b0, bus_b.rd_busy[0]}, {31'b0, vecs[n].bb0});
            chk($sformatf("v%0d_b_data1", n), bus_b.rd_data[1], vecs[n].bd1);
            chk($sformatf("v%0d_b_busy1", n), {31'b0, bus_b.rd_busy[1]}, {31'b0, vecs[n].bb1});
            tick();
        end

        // randomized traffic, addresses mostly in a small window to force collisions
        for (int c = 0; c < 400; c++) begin
            s_wen = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                s_wa[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 7));
                s_wd[i] = $urandom;
                s_ra[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(0, 7));
            end
            s_bset = 1'($urandom_range(0, 1));
            s_ba   = 5'($urandom_range(0, 7));
            apply();
            @(negedge clk);
            chk_model($sformatf("rnd%0d", c));
            tick();
        end

        // asynchronous reset mid-operation
        set_idle();
        s_wen = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 32'hDEADBEEF;
        apply();
        tick();
        set_idle();
        s_bset = 1'b1; s_ba = 5'd6;
        apply();
        tick();
        set_idle();
        s_ra[0] = 5'd5; s_ra[1] = 5'd6;
        apply();
        #2;
        chk_model("pre_reset");
        s_wen = 2'b01; s_wa[0] = 5'd5; s_wd[0] = 32'hCAFEF00D;
        apply();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_all_zero("reset_async");
        @(posedge clk);
        #1;
        chk_all_zero("reset_after_edge");
        set_idle();
        apply();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_model("post_reset");
        tick();
        @(negedge clk);
        chk_model("post_reset2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
